// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch queue between a synchronous imem and
// the fetch/decode boundary.
//
// Issues one imem read per cycle from its own fetch PC. Each returned word is
// tagged with its PC and buffered in a DEPTH-entry FIFO, which decode drains
// through out_valid/deq. A redirect flushes both the buffered words and the
// word in flight, then restarts fetch at redirect_pc.
//
// Optional feature: define FQ_BYPASS_EN to present a returning word directly
// on the outputs when the FIFO is empty. This saves one cycle of fill latency.
//
// Ports:
//   clock, reset        rising-edge clock; async active-high reset
//   address_imem        imem read address (fetch PC register)
//   q_imem              imem read data, one cycle after address
//   redirect/_pc        flush and restart fetch at redirect_pc
//   deq                 decode consumes the head entry
//   out_valid/_instr/_pc  head entry
//   count               occupied FIFO entries
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [PC_W-1:0]          address_imem,
  input  logic [PC_W-1:0]          q_imem,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     deq,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_instr,
  output logic [PC_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0] instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [PC_W-1:0] fetchPc, inflightPc;
  logic            inflight;
  logic [AW-1:0]   rdPtr, wrPtr;
  logic [CW-1:0]   occ, occPlus;
  logic            issue, empty, full, bypass, deqHit, rdEn, wrEn;

  // An in-flight word is counted as occupied. This guarantees that a slot
  // is free when the word returns, so overflow cannot happen.
  assign occPlus = occ + CW'(inflight);
  assign issue   = !redirect && (occPlus < CW'(DEPTH));
  assign empty   = (occ == '0);
  assign full    = (occ == CW'(DEPTH));

`ifdef FQ_BYPASS_EN
  assign bypass = empty && inflight && !redirect;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid    = !empty || bypass;
  assign out_instr    = bypass ? q_imem     : entries[rdPtr].instr;
  assign out_pc       = bypass ? inflightPc : entries[rdPtr].pc;
  assign address_imem = fetchPc;
  assign count        = occ;

  // Redirect overrides any dequeue or write in the same cycle. A word that
  // is consumed through the bypass path is never stored in the FIFO.
  assign deqHit = deq && out_valid && !redirect;
  assign rdEn   = deqHit && !empty;
  assign wrEn   = inflight && !redirect && !full && !(bypass && deq);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetchPc    <= '0;
      inflight   <= 1'b0;
      inflightPc <= '0;
      rdPtr      <= '0;
      wrPtr      <= '0;
      occ        <= '0;
    end else if (redirect) begin
      fetchPc  <= redirect_pc;
      inflight <= 1'b0;
      rdPtr    <= '0;
      wrPtr    <= '0;
      occ      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflightPc <= fetchPc;
        fetchPc    <= fetchPc + PC_W'(1);
      end
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      case ({wrEn, rdEn})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // The storage array is cleared on reset so that the head outputs read 0
  // instead of X while the queue is empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (wrEn) begin
      entries[wrPtr] <= '{instr: q_imem, pc: inflightPc};
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
`ifdef FQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] address_imem, q_imem, redirect_pc, out_instr, out_pc;
  logic            redirect, deq, out_valid;
  logic [2:0]      count;

  fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  always #5 clock = ~clock;

  // Synchronous imem model: word = 0x100 + address, one cycle later.
  always @(posedge clock) q_imem <= address_imem + 32'h100;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sbq[$];
  int   errs   = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expectRun(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) sbq.push_back('{pc: pc0 + i, instr: pc0 + i + 32'h100});
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: each accepted dequeue must match the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && out_valid && deq && !redirect) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_deq: got pc %h expected no entry", out_pc);
      end else begin
        e = sbq.pop_front();
        chk("deq_pc", out_pc, e.pc);
        chk("deq_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    deq = 0; redirect = 0; redirect_pc = '0;
    cyc(3);
    chk("rst_addr", address_imem, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);

    // Fill from reset with decode draining every cycle.
    expectRun(32'h0, 12 - LAT);
    deq = 1; reset = 0;
    for (int c = 0; c < 12; c++) begin
      chk("fill_valid", 32'(out_valid), 32'(c >= LAT));
      cyc();
    end
    deq = 0;

    // Backpressure: the queue fills to DEPTH and issue stops.
    reset = 1; cyc(2); reset = 0;
    cyc(10);
    chk("bp_count", 32'(count), 32'd4);
    chk("bp_addr", address_imem, 32'd4);
    cyc();
    chk("bp_addr_hold", address_imem, 32'd4);
    expectRun(32'h0, 1);
    deq = 1; cyc(); deq = 0;
    chk("bp_count_after_deq", 32'(count), 32'd3);
    chk("bp_addr_after_deq", address_imem, 32'd4);
    cyc(2);
    chk("bp_count_refill", 32'(count), 32'd4);
    chk("bp_addr_advance", address_imem, 32'd5);

    // Redirect at count=3 with a read in flight.
    expectRun(32'h1, 1);
    deq = 1; cyc(); deq = 0;
    cyc();
    chk("rd_pre_count", 32'(count), 32'd3);
    redirect = 1; redirect_pc = 32'h40; cyc();
    redirect = 0;
    chk("rd_flush_count", 32'(count), 32'd0);
    chk("rd_flush_valid", 32'(out_valid), 32'd0);
    expectRun(32'h40, 10 - LAT);
    deq = 1;
    for (int c = 0; c < 10; c++) begin
      chk("rd_valid", 32'(out_valid), 32'(c >= LAT));
      if (c == LAT) chk("rd_first_pc", out_pc, 32'h40);
      cyc();
    end
    deq = 0;

    // Redirect coinciding with deq at count=2.
    redirect = 1; redirect_pc = 32'h80; cyc();
    redirect = 0; cyc(3);
    chk("rdq_pre_count", 32'(count), 32'd2);
    redirect = 1; redirect_pc = 32'h200; deq = 1; cyc();
    redirect = 0;
    chk("rdq_count", 32'(count), 32'd0);
    chk("rdq_valid", 32'(out_valid), 32'd0);
    expectRun(32'h200, 8 - LAT);
    for (int c = 0; c < 8; c++) cyc();
    deq = 0;

    // Steady write+deq at count=2 across several pointer wraps.
    redirect = 1; redirect_pc = 32'h300; cyc();
    redirect = 0; cyc(3);
    expectRun(32'h300, 20);
    deq = 1;
    for (int c = 0; c < 20; c++) begin
      chk("steady_count", 32'(count), 32'd2);
      cyc();
    end
    deq = 0;
    chk("steady_end_count", 32'(count), 32'd2);
    cyc();
    chk("pre_reset_count", 32'(count), 32'd3);

    // Asynchronous reset in the middle of a cycle.
    #2 reset = 1;
    #1;
    chk("async_addr", address_imem, 32'h0);
    chk("async_count", 32'(count), 32'h0);
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_instr", out_instr, 32'h0);
    chk("async_pc", out_pc, 32'h0);
    cyc(2);
    reset = 0;
    cyc(2);

    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
